// File: rtl/bird_physics_if.sv
// Button inputs and game-state outputs shared between bird_physics and whatever drives or consumes it.
// The master side owns the buttons. The slave side (the physics block) owns the position and state flags.
interface bird_physics_if;
   logic       flap;
   logic       pause;
   logic [9:0] y;
   logic       gamestate;
   logic       dead;
   logic       tick;

   modport master (output flap, output pause, input y, input gamestate, input dead, input tick);
   modport slave  (input flap, input pause, output y, output gamestate, output dead, output tick);
endinterface

// File: rtl/bird_physics.sv
// Bird vertical physics: button conditioning, frame-tick divider and a fixed-point gravity/flap FSM
// that produces the bird's screen row and the run/dead flags for the renderer.
module bird_physics #(
   parameter int TICK_DIV   = 1666667,
   parameter int DEB_CYCLES = 1000000,
   parameter int Y_START    = 240,
   parameter int Y_MAX      = 464,
   parameter int GRAVITY    = 6,
   parameter int FLAP_VEL   = -80,
   parameter int VMAX       = 128
) (
   input logic          clk,
   input logic          clr,
   bird_physics_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic        [13:0] POS_START  = 14'(Y_START * 16);
   localparam logic signed [14:0] POS_GROUND = 15'(Y_MAX * 16);
   localparam logic signed [9:0]  V_FLAP     = 10'(FLAP_VEL);
   localparam logic signed [10:0] V_MAX      = 11'(VMAX);
   localparam logic signed [10:0] V_GRAV     = 11'(GRAVITY);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   state_t             state, state_n;
   logic               flap_s1, flap_s2, pause_s1, pause_s2;
   logic [DW-1:0]      deb_cnt;
   logic               flap_lvl, flap_lvl_d, flap_evt;
   logic [TW-1:0]      tick_cnt;
   logic               tick_now;
   logic [13:0]        pos, pos_n;
   logic signed [9:0]  vel, vel_nx, vel_sat, vel_new;
   logic signed [10:0] vel_sum;
   logic signed [14:0] pos_sum;
   logic               pend, pend_n;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         flap_s1  <= 1'b0;
         flap_s2  <= 1'b0;
         pause_s1 <= 1'b0;
         pause_s2 <= 1'b0;
      end else begin
         flap_s1  <= bus.flap;
         flap_s2  <= flap_s1;
         pause_s1 <= bus.pause;
         pause_s2 <= pause_s1;
      end
   end

   // The accepted level only moves after DEB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         deb_cnt    <= '0;
         flap_lvl   <= 1'b0;
         flap_lvl_d <= 1'b0;
      end else begin
         flap_lvl_d <= flap_lvl;
         if (flap_s2 == flap_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            flap_lvl <= flap_s2;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign flap_evt = flap_lvl & ~flap_lvl_d;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)           tick_cnt <= '0;
      else if (tick_now) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick_now = (tick_cnt == TW'(TICK_DIV - 1));

   // Candidate motion for this tick; a flap overrides the terminal-velocity clamp.
   always_comb begin
      vel_sum = $signed({vel[9], vel}) + V_GRAV;
      vel_sat = (vel_sum > V_MAX) ? V_MAX[9:0] : vel_sum[9:0];
      vel_new = (pend | flap_evt) ? V_FLAP : vel_sat;
      pos_sum = $signed({1'b0, pos}) + $signed({{5{vel_new[9]}}, vel_new});
   end

   always_comb begin
      state_n = state;
      pos_n   = pos;
      vel_nx  = vel;
      pend_n  = pend;
      case (state)
         IDLE: begin
            pos_n  = POS_START;
            vel_nx = '0;
            pend_n = 1'b0;
            if (flap_evt) begin
               state_n = RUN;
               pend_n  = 1'b1;
            end
         end
         RUN: begin
            if (!pause_s2) begin
               if (tick_now) begin
                  pend_n = 1'b0;
                  if (pos_sum < 0) begin
                     pos_n  = '0;
                     vel_nx = '0;
                  end else if (pos_sum >= POS_GROUND) begin
                     pos_n   = POS_GROUND[13:0];
                     vel_nx  = '0;
                     state_n = DEAD;
                  end else begin
                     pos_n  = pos_sum[13:0];
                     vel_nx = vel_new;
                  end
               end else if (flap_evt) begin
                  pend_n = 1'b1;
               end
            end
         end
         DEAD: begin
            if (flap_evt) begin
               state_n = IDLE;
               pos_n   = POS_START;
               vel_nx  = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         pos   <= POS_START;
         vel   <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_n;
         pos   <= pos_n;
         vel   <= vel_nx;
         pend  <= pend_n;
      end
   end

   assign bus.y         = pos[13:4];
   assign bus.gamestate = (state == RUN);
   assign bus.dead      = (state == DEAD);
   assign bus.tick      = tick_now;
endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics with a 4-cycle tick and 2-sample debounce.
// Expected positions come from hand-worked values and a small integer physics model.
module tb_bird_physics;
   typedef struct {
      logic pause;
      int   exp_y;
      logic exp_gs;
      logic exp_dead;
   } vec_t;

   logic clk;
   logic clr;
   int   n_vec;
   int   n_bad;
   int   m_pos;
   int   m_vel;
   bit   m_dead;
   vec_t vecs[11];

   bird_physics_if bif ();

   bird_physics #(
      .TICK_DIV  (4),
      .DEB_CYCLES(2)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_vec++;
      if (actual != expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // Returns at the falling edge just after the tick's update edge, i.e. at count 0.
   task automatic wait_tick();
      bit seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         if (bif.tick) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_bad++;
         $display("[TB] FAIL tick_timeout: got no tick, want tick within 16 cycles");
      end
      @(negedge clk);
   endtask

   task automatic model_step(input bit fl);
      int pn;
      if (fl) m_vel = -80;
      else    m_vel = (m_vel + 6 > 128) ? 128 : m_vel + 6;
      pn = m_pos + m_vel;
      if (pn < 0) begin
         m_pos = 0;
         m_vel = 0;
      end else if (pn >= 464 * 16) begin
         m_pos  = 464 * 16;
         m_vel  = 0;
         m_dead = 1'b1;
      end else begin
         m_pos = pn;
      end
   endtask

   task automatic check_model(input string name);
      check_output({name, "_y"}, int'(bif.y), m_pos / 16);
      check_output({name, "_dead"}, int'(bif.dead), int'(m_dead));
   endtask

   task automatic press();
      bif.flap = 1'b1;
      repeat (4) @(negedge clk);
      bif.flap = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      bif.pause = v.pause;
      wait_tick();
      if (!v.pause) model_step(1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      m_dead = 1'b0;
      vecs[0]  = '{1'b0, 226, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 222, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 218, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 215, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 212, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 210, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 210, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 210, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 210, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 208, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 206, 1'b1, 1'b0};

      clr = 1'b1;
      bif.flap = 1'b0;
      bif.pause = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_y", int'(bif.y), 240);
      check_output("reset_gamestate", int'(bif.gamestate), 0);
      check_output("reset_dead", int'(bif.dead), 0);
      check_output("reset_tick", int'(bif.tick), 0);
      clr = 1'b0;

      repeat (2) @(negedge clk);
      check_output("tick_early", int'(bif.tick), 0);
      @(negedge clk);
      check_output("tick_first", int'(bif.tick), 1);
      @(negedge clk);
      check_output("idle_tick_y", int'(bif.y), 240);

      $display("[TB] start from IDLE");
      press();
      @(negedge clk);
      check_output("start_gamestate", int'(bif.gamestate), 1);
      check_output("start_y", int'(bif.y), 240);
      wait_tick();
      m_pos = 240 * 16;
      m_vel = 0;
      model_step(1'b1);
      check_output("first_tick_y", int'(bif.y), 235);
      wait_tick();
      model_step(1'b0);
      check_output("second_tick_y", int'(bif.y), 230);

      for (int i = 0; i < 11; i++) begin
         apply_stimulus(vecs[i]);
         check_output($sformatf("vec%0d_y", i), int'(bif.y), vecs[i].exp_y);
         check_output($sformatf("vec%0d_gs", i), int'(bif.gamestate), int'(vecs[i].exp_gs));
         check_output($sformatf("vec%0d_dead", i), int'(bif.dead), int'(vecs[i].exp_dead));
      end

      $display("[TB] free fall to ground");
      for (int guard = 0; guard < 200 && !m_dead; guard++) begin
         wait_tick();
         model_step(1'b0);
         check_model($sformatf("fall%0d", guard));
      end
      check_output("ground_y", int'(bif.y), 464);
      check_output("ground_dead", int'(bif.dead), 1);
      check_output("ground_gamestate", int'(bif.gamestate), 0);
      for (int i = 0; i < 2; i++) begin
         wait_tick();
         check_output($sformatf("dead_hold%0d_y", i), int'(bif.y), 464);
      end

      press();
      @(negedge clk);
      check_output("restart_idle_y", int'(bif.y), 240);
      check_output("restart_idle_dead", int'(bif.dead), 0);
      check_output("restart_idle_gs", int'(bif.gamestate), 0);
      wait_tick();
      check_output("restart_idle_tick_y", int'(bif.y), 240);
      press();
      @(negedge clk);
      check_output("restart_run_gs", int'(bif.gamestate), 1);
      wait_tick();
      m_pos = 240 * 16;
      m_vel = 0;
      m_dead = 1'b0;
      model_step(1'b1);
      check_output("restart_first_y", int'(bif.y), 235);

      // Flap accepted in the very cycle a tick fires: gravity tick, then flap tick.
      repeat (3) @(negedge clk);
      bif.flap = 1'b1;
      repeat (4) @(negedge clk);
      bif.flap = 1'b0;
      @(negedge clk);
      model_step(1'b0);
      model_step(1'b1);
      check_output("coincident_y", int'(bif.y), 225);
      for (int i = 0; i < 2; i++) begin
         wait_tick();
         model_step(1'b0);
         check_model($sformatf("post_coin%0d", i));
      end

      $display("[TB] pause for 20 ticks");
      bif.pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5 || i == 12) press();
         else wait_tick();
         check_output($sformatf("pause%0d_y", i), int'(bif.y), 216);
      end
      check_output("pause_gamestate", int'(bif.gamestate), 1);
      bif.pause = 1'b0;
      wait_tick();
      model_step(1'b0);
      check_output("resume_y", int'(bif.y), 212);

      bif.flap = 1'b1;
      @(negedge clk);
      bif.flap = 1'b0;
      wait_tick();
      model_step(1'b0);
      check_model("glitch");

      $display("[TB] climb to ceiling");
      for (int k = 0; k < 40; k++) begin
         press();
         model_step(1'b0);
         check_model($sformatf("climb%0d_g", k));
         wait_tick();
         model_step(1'b1);
         check_model($sformatf("climb%0d_f", k));
      end
      check_output("ceiling_y", int'(bif.y), 0);
      check_output("ceiling_gs", int'(bif.gamestate), 1);

      @(negedge clk);
      #2 clr = 1'b1;
      #1;
      check_output("async_clr_y", int'(bif.y), 240);
      check_output("async_clr_gs", int'(bif.gamestate), 0);
      check_output("async_clr_dead", int'(bif.dead), 0);
      check_output("async_clr_tick", int'(bif.tick), 0);
      @(negedge clk);
      clr = 1'b0;
      wait_tick();
      check_output("post_clr_y", int'(bif.y), 240);
      check_output("post_clr_gs", int'(bif.gamestate), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
